// File: rtl/uart_txfifo_pkg.sv
// uart_txfifo_pkg: shared uart constants, tx FIFO FSM encodings and depth derivation
package uart_txfifo_pkg;
  localparam int UART_DW = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAITHI = 2'd2;
  localparam logic [1:0] S_WAITLO = 2'd3;
  function automatic int depth_of(input int adrw);
    return 1 << adrw;
  endfunction
endpackage

// File: rtl/uart_txfifo_fifomem.sv
// uart_fifomem_m: single write port, registered read port storage for the uart tx FIFO
module uart_fifomem_m
  import uart_txfifo_pkg::*;
#(
  parameter int ADRW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADRW-1:0]    wa,
  input  logic [UART_DW-1:0] wd,
  input  logic               re,
  input  logic [ADRW-1:0]    ra,
  output logic [UART_DW-1:0] rd
);
  localparam int DEPTH = depth_of(ADRW);
  logic [UART_DW-1:0] mem [0:DEPTH-1];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // read register only updates on re, so it holds the last loaded byte between frames
  always_ff @(posedge clk)
    if (!rst_n) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/uart_txfifo.sv
// uart_txfifo: byte FIFO feeding uart_m with one load strobe per transmitted frame
module uart_txfifo
  import uart_txfifo_pkg::*;
#(
  parameter int ADRW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr,
  input  logic [UART_DW-1:0] wd,
  input  logic               txbusy,
  output logic               load,
  output logic [UART_DW-1:0] d,
  output logic               full,
  output logic               empty,
  output logic [ADRW:0]      count,
  output logic               ovf
);
  localparam int DEPTH = depth_of(ADRW);
  logic [1:0] state, state_n;
  logic [ADRW-1:0] wp, rp;
  logic push, pop, go;
  logic [ADRW:0] count_n;
  assign go = state == S_IDLE && !empty && !txbusy;
  assign pop = state == S_LOAD;
  assign push = wr && !full;
  assign load = pop;
  assign count_n = count + (ADRW+1)'(push) - (ADRW+1)'(pop);
  always_comb
    state_n = state == S_IDLE ? (go ? S_LOAD : S_IDLE) :
              state == S_LOAD ? S_WAITHI :
              state == S_WAITHI ? (txbusy ? S_WAITLO : S_WAITHI) :
              (txbusy ? S_WAITLO : S_IDLE);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      if (push) wp <= wp + ADRW'(1);
      if (pop) rp <= rp + ADRW'(1);
      count <= count_n;
      empty <= count_n == '0;
      full <= count_n == (ADRW+1)'(DEPTH);
      if (wr && full) ovf <= 1'b1;
    end
  // head byte is fetched on the IDLE->LOAD edge so d is valid throughout LOAD
  uart_fifomem_m #(.ADRW(ADRW)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .we(push),
    .wa(wp),
    .wd(wd),
    .re(go),
    .ra(rp),
    .rd(d)
  );
endmodule
